// File: rtl/lh_ecdsa_stage.sv
// Pairs logic hashes with type1 header packets in arrival order, issues one verify job per
// packet and then streams that packet's header beats to the ECDSA engine.
module lh_ecdsa_stage #(
  parameter int HASH_DEPTH_NBITS = 3,
  parameter int PKT_DEPTH_NBITS  = 6,
  parameter int LOGIC_HASH_NBITS = 256,
  parameter int DATA_PATH_NBITS  = 128,
  parameter int FID_NBITS        = 16,
  parameter int SERIAL_NUM_NBITS = 32,
  parameter int SERIAL_NUM_POS   = 127
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        lh_ecdsa_hash_valid,
  input  logic [LOGIC_HASH_NBITS-1:0] lh_ecdsa_hash_data,
  input  logic                        lh_ecdsa_valid,
  input  logic [DATA_PATH_NBITS-1:0]  lh_ecdsa_hdr_data,
  input  logic [FID_NBITS-1:0]        lh_ecdsa_meta_data,
  input  logic                        lh_ecdsa_sop,
  input  logic                        lh_ecdsa_eop,
  output logic                        ecdsa_lh_ready,
  output logic                        job_valid,
  output logic [LOGIC_HASH_NBITS-1:0] job_hash,
  output logic [FID_NBITS-1:0]        job_fid,
  output logic [SERIAL_NUM_NBITS-1:0] job_sn,
  input  logic                        job_ready,
  output logic                        ecdsa_valid,
  output logic [DATA_PATH_NBITS-1:0]  ecdsa_hdr_data,
  output logic                        ecdsa_sop,
  output logic                        ecdsa_eop,
  input  logic                        ecdsa_ready,
  output logic                        err_overflow,
  output logic [15:0]                 job_cnt
);

  localparam int HDEPTH = 1 << HASH_DEPTH_NBITS;
  localparam int PDEPTH = 1 << PKT_DEPTH_NBITS;
  localparam int HCW    = HASH_DEPTH_NBITS + 1;
  localparam int PCW    = PKT_DEPTH_NBITS + 1;
  localparam int MW     = FID_NBITS + SERIAL_NUM_NBITS;
  localparam int PW     = DATA_PATH_NBITS + 2;
  localparam logic [HCW-1:0] HFULL      = HCW'(HDEPTH);
  localparam logic [HCW-1:0] HREADY_MAX = HCW'(HDEPTH - 2);
  localparam logic [PCW-1:0] PFULL      = PCW'(PDEPTH);
  localparam logic [PCW-1:0] PREADY_MAX = PCW'(PDEPTH - 16);

  typedef enum logic [1:0] {IDLE, JOB, DATA} state_e;

  state_e state_q, state_d;

  logic [LOGIC_HASH_NBITS-1:0] hashMem [HDEPTH];
  logic [MW-1:0]               metaMem [HDEPTH];
  logic [PW-1:0]               pktMem  [PDEPTH];

  logic [HASH_DEPTH_NBITS-1:0] hashWr_q, hashRd_q, metaWr_q, metaRd_q;
  logic [PKT_DEPTH_NBITS-1:0]  pktWr_q, pktRd_q;
  logic [HCW-1:0]              hashCnt_q, hashCnt_d, metaCnt_q, metaCnt_d;
  logic [PCW-1:0]              pktCnt_q, pktCnt_d;

  logic hashPush, hashPop, hashDrop;
  logic metaWrEn, metaPush, metaPop, metaDrop;
  logic pktPush, pktPop, pktDrop;
  logic jobLoad, jobAccept;
  logic readyQ;
  logic errQ;
  logic [15:0] jobCntQ;
  logic [LOGIC_HASH_NBITS-1:0] jobHash_q;
  logic [MW-1:0]               jobMeta_q;
  logic [MW-1:0]               metaIn;
  logic [PW-1:0]               pktHead;

  // A full FIFO still accepts a write when the same cycle pops it; otherwise the entry is dropped.
  assign hashDrop = lh_ecdsa_hash_valid && (hashCnt_q == HFULL) && !hashPop;
  assign hashPush = lh_ecdsa_hash_valid && !hashDrop;
  assign metaWrEn = lh_ecdsa_valid && lh_ecdsa_sop;
  assign metaDrop = metaWrEn && (metaCnt_q == HFULL) && !metaPop;
  assign metaPush = metaWrEn && !metaDrop;
  assign pktDrop  = lh_ecdsa_valid && (pktCnt_q == PFULL) && !pktPop;
  assign pktPush  = lh_ecdsa_valid && !pktDrop;

  assign hashCnt_d = hashCnt_q + HCW'(hashPush) - HCW'(hashPop);
  assign metaCnt_d = metaCnt_q + HCW'(metaPush) - HCW'(metaPop);
  assign pktCnt_d  = pktCnt_q + PCW'(pktPush) - PCW'(pktPop);

  assign metaIn  = {lh_ecdsa_meta_data, lh_ecdsa_hdr_data[SERIAL_NUM_POS -: SERIAL_NUM_NBITS]};
  assign pktHead = pktMem[pktRd_q];

  always_comb begin
    state_d   = state_q;
    hashPop   = 1'b0;
    metaPop   = 1'b0;
    pktPop    = 1'b0;
    jobLoad   = 1'b0;
    jobAccept = 1'b0;
    case (state_q)
      IDLE: begin
        if (hashCnt_q != '0 && metaCnt_q != '0) begin
          hashPop = 1'b1;
          metaPop = 1'b1;
          jobLoad = 1'b1;
          state_d = JOB;
        end
      end
      JOB: begin
        if (job_ready) begin
          jobAccept = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (pktCnt_q != '0 && ecdsa_ready) begin
          pktPop = 1'b1;
          if (pktHead[0]) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hashWr_q  <= '0;
      hashRd_q  <= '0;
      hashCnt_q <= '0;
      metaWr_q  <= '0;
      metaRd_q  <= '0;
      metaCnt_q <= '0;
      pktWr_q   <= '0;
      pktRd_q   <= '0;
      pktCnt_q  <= '0;
      readyQ    <= 1'b0;
      errQ      <= 1'b0;
      jobCntQ   <= '0;
    end else begin
      state_q   <= state_d;
      hashCnt_q <= hashCnt_d;
      metaCnt_q <= metaCnt_d;
      pktCnt_q  <= pktCnt_d;
      if (hashPush) hashWr_q <= hashWr_q + 1'b1;
      if (hashPop)  hashRd_q <= hashRd_q + 1'b1;
      if (metaPush) metaWr_q <= metaWr_q + 1'b1;
      if (metaPop)  metaRd_q <= metaRd_q + 1'b1;
      if (pktPush)  pktWr_q  <= pktWr_q + 1'b1;
      if (pktPop)   pktRd_q  <= pktRd_q + 1'b1;
      // Ready reflects the occupancy that will hold after this cycle's writes and pops.
      readyQ <= (pktCnt_d <= PREADY_MAX) && (hashCnt_d <= HREADY_MAX);
      if (hashDrop || metaDrop || pktDrop) errQ <= 1'b1;
      if (jobAccept) jobCntQ <= jobCntQ + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (hashPush) hashMem[hashWr_q] <= lh_ecdsa_hash_data;
    if (metaPush) metaMem[metaWr_q] <= metaIn;
    if (pktPush)  pktMem[pktWr_q]   <= {lh_ecdsa_hdr_data, lh_ecdsa_sop, lh_ecdsa_eop};
    if (jobLoad) begin
      jobHash_q <= hashMem[hashRd_q];
      jobMeta_q <= metaMem[metaRd_q];
    end
  end

  assign job_valid      = (state_q == JOB);
  assign job_hash       = jobHash_q;
  assign job_fid        = jobMeta_q[MW-1 -: FID_NBITS];
  assign job_sn         = jobMeta_q[SERIAL_NUM_NBITS-1:0];
  assign ecdsa_valid    = (state_q == DATA) && (pktCnt_q != '0);
  assign ecdsa_hdr_data = pktHead[PW-1:2];
  assign ecdsa_sop      = pktHead[1];
  assign ecdsa_eop      = pktHead[0];
  assign ecdsa_lh_ready = readyQ;
  assign err_overflow   = errQ;
  assign job_cnt        = jobCntQ;

endmodule

// File: tb/tb_lh_ecdsa_stage.sv
// Randomized self-checking bench for lh_ecdsa_stage: a queue-based model pairs hashes with
// packets in order and predicts the job descriptors and beat stream the DUT must produce.
module tb_lh_ecdsa_stage;

  localparam int HW = 256;
  localparam int DW = 128;
  localparam int FW = 16;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          lh_ecdsa_hash_valid;
  logic [HW-1:0] lh_ecdsa_hash_data;
  logic          lh_ecdsa_valid;
  logic [DW-1:0] lh_ecdsa_hdr_data;
  logic [FW-1:0] lh_ecdsa_meta_data;
  logic          lh_ecdsa_sop, lh_ecdsa_eop;
  logic          ecdsa_lh_ready;
  logic          job_valid;
  logic [HW-1:0] job_hash;
  logic [FW-1:0] job_fid;
  logic [SW-1:0] job_sn;
  logic          job_ready;
  logic          ecdsa_valid;
  logic [DW-1:0] ecdsa_hdr_data;
  logic          ecdsa_sop, ecdsa_eop;
  logic          ecdsa_ready;
  logic          err_overflow;
  logic [15:0]   job_cnt;

  lh_ecdsa_stage dut (
    .clk(clk), .reset(reset),
    .lh_ecdsa_hash_valid(lh_ecdsa_hash_valid), .lh_ecdsa_hash_data(lh_ecdsa_hash_data),
    .lh_ecdsa_valid(lh_ecdsa_valid), .lh_ecdsa_hdr_data(lh_ecdsa_hdr_data),
    .lh_ecdsa_meta_data(lh_ecdsa_meta_data), .lh_ecdsa_sop(lh_ecdsa_sop), .lh_ecdsa_eop(lh_ecdsa_eop),
    .ecdsa_lh_ready(ecdsa_lh_ready),
    .job_valid(job_valid), .job_hash(job_hash), .job_fid(job_fid), .job_sn(job_sn), .job_ready(job_ready),
    .ecdsa_valid(ecdsa_valid), .ecdsa_hdr_data(ecdsa_hdr_data), .ecdsa_sop(ecdsa_sop),
    .ecdsa_eop(ecdsa_eop), .ecdsa_ready(ecdsa_ready),
    .err_overflow(err_overflow), .job_cnt(job_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int totalJobs = 0;
  bit randReady = 1'b0;
  logic expErr = 1'b0;

  logic [HW+FW+SW-1:0] expJobs[$], obsJobs[$];
  logic [DW+1:0]       expBeats[$], obsBeats[$];
  logic [HW-1:0]       mHash[$];
  logic [FW+SW-1:0]    mMeta[$];

  // Record every completed handshake, away from the sampling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (job_valid && job_ready) obsJobs.push_back({job_hash, job_fid, job_sn});
      if (ecdsa_valid && ecdsa_ready) obsBeats.push_back({ecdsa_hdr_data, ecdsa_sop, ecdsa_eop});
    end
  end

  initial begin
    #4000000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  // Applies one cycle of input, updates the reference model, then returns inputs to idle.
  task automatic applyStimulus(input logic hv, input logic [HW-1:0] h, input logic v,
                               input logic [DW-1:0] hdr, input logic [FW-1:0] fid,
                               input logic s, input logic e);
    logic [HW-1:0] th;
    logic [FW+SW-1:0] tm;
    lh_ecdsa_hash_valid = hv; lh_ecdsa_hash_data = h;
    lh_ecdsa_valid = v; lh_ecdsa_hdr_data = hdr; lh_ecdsa_meta_data = fid;
    lh_ecdsa_sop = s; lh_ecdsa_eop = e;
    if (randReady) begin
      job_ready   = ($urandom_range(0, 1) == 1);
      ecdsa_ready = ($urandom_range(0, 3) != 0);
    end
    if (hv) begin
      if (mHash.size() >= 8) expErr = 1'b1;
      else mHash.push_back(h);
    end
    if (v) begin
      expBeats.push_back({hdr, s, e});
      if (s) mMeta.push_back({fid, hdr[DW-1 -: SW]});
    end
    while (mHash.size() > 0 && mMeta.size() > 0) begin
      th = mHash.pop_front();
      tm = mMeta.pop_front();
      expJobs.push_back({th, tm});
    end
    @(posedge clk); #1;
    lh_ecdsa_hash_valid = 1'b0; lh_ecdsa_valid = 1'b0; lh_ecdsa_sop = 1'b0; lh_ecdsa_eop = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  function automatic logic [DW-1:0] mkHdr(input logic [SW-1:0] sn);
    return {sn, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [HW-1:0] mkHash();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic sendPacket(input logic [FW-1:0] fid, input logic [SW-1:0] sn, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b1, mkHdr(sn), fid, i == 0, i == n - 1);
  endtask

  task automatic drain(input int maxCycles);
    int c = 0;
    while ((obsBeats.size() < expBeats.size() || obsJobs.size() < expJobs.size()) && c < maxCycles) begin
      idle();
      c++;
    end
    repeat (4) idle();
  endtask

  task automatic clearQueues();
    totalJobs += expJobs.size();
    expJobs.delete(); obsJobs.delete(); expBeats.delete(); obsBeats.delete();
    mHash.delete(); mMeta.delete();
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    if (obsJobs.size() != expJobs.size()) begin
      failures++;
      $display("[TB] FAIL %s_job_count got %0d expected %0d", tag, obsJobs.size(), expJobs.size());
    end
    foreach (expJobs[i]) if (i < obsJobs.size()) begin
      checks++;
      if (obsJobs[i] !== expJobs[i]) begin
        failures++;
        $display("[TB] FAIL %s_job%0d got %h expected %h", tag, i, obsJobs[i], expJobs[i]);
      end
    end
    checks++;
    if (obsBeats.size() != expBeats.size()) begin
      failures++;
      $display("[TB] FAIL %s_beat_count got %0d expected %0d", tag, obsBeats.size(), expBeats.size());
    end
    foreach (expBeats[i]) if (i < obsBeats.size()) begin
      checks++;
      if (obsBeats[i] !== expBeats[i]) begin
        failures++;
        $display("[TB] FAIL %s_beat%0d got %h expected %h", tag, i, obsBeats[i], expBeats[i]);
      end
    end
    checks++;
    if (job_cnt !== 16'(totalJobs + expJobs.size())) begin
      failures++;
      $display("[TB] FAIL %s_job_cnt got %0d expected %0d", tag, job_cnt, totalJobs + expJobs.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (job_valid !== 1'b0)      begin failures++; $display("[TB] FAIL rst_job_valid got %b expected 0", job_valid); end
    if (ecdsa_valid !== 1'b0)    begin failures++; $display("[TB] FAIL rst_ecdsa_valid got %b expected 0", ecdsa_valid); end
    if (err_overflow !== 1'b0)   begin failures++; $display("[TB] FAIL rst_err got %b expected 0", err_overflow); end
    if (job_cnt !== 16'd0)       begin failures++; $display("[TB] FAIL rst_job_cnt got %0d expected 0", job_cnt); end
    if (ecdsa_lh_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready got %b expected 0", ecdsa_lh_ready); end
    reset = 1'b0;
    expErr = 1'b0;
    totalJobs = 0;
    idle();
    checks++;
    if (ecdsa_lh_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_ready_after got %b expected 1", ecdsa_lh_ready); end
  endtask

  task automatic test_basic();
    logic [HW-1:0] h;
    h = {32{8'hA5}};
    job_ready = 1'b1; ecdsa_ready = 1'b1;
    applyStimulus(1'b1, h, 1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, mkHdr(32'h12), 16'd5, 1'b1, 1'b0);
    checks++;
    if (job_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_early_job got %b expected 0", job_valid); end
    applyStimulus(1'b0, '0, 1'b1, mkHdr(32'h12), 16'd5, 1'b0, 1'b0);
    checks++;
    if ({job_valid, job_hash, job_fid, job_sn} !== {1'b1, h, 16'd5, 32'h12}) begin
      failures++;
      $display("[TB] FAIL basic_job_latency got v=%b fid=%0d sn=%h expected v=1 fid=5 sn=12", job_valid, job_fid, job_sn);
    end
    applyStimulus(1'b0, '0, 1'b1, mkHdr(32'h12), 16'd5, 1'b0, 1'b1);
    drain(200);
    checkOutput("basic");
    clearQueues();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    job_ready = 1'b0; ecdsa_ready = 1'b1;
    applyStimulus(1'b1, mkHash(), 1'b0, '0, '0, 1'b0, 1'b0);
    sendPacket(16'd9, $urandom, 3);
    for (int i = 0; i < 10; i++) begin
      idle();
      if (!job_valid || ecdsa_valid || {job_hash, job_fid, job_sn} !== expJobs[0]) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL bp_hold bad_cycles=%0d expected 0", bad); end
    job_ready = 1'b1;
    drain(200);
    checkOutput("bp");
    clearQueues();
  endtask

  task automatic test_hash_late();
    int seen = 0;
    sendPacket(16'd5, 32'h12, 3);
    for (int i = 0; i < 20; i++) begin
      idle();
      if (job_valid || ecdsa_valid) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("[TB] FAIL late_idle active_cycles=%0d expected 0", seen); end
    applyStimulus(1'b1, {32{8'hA5}}, 1'b0, '0, '0, 1'b0, 1'b0);
    drain(200);
    checkOutput("late");
    clearQueues();
  endtask

  task automatic test_ready_threshold();
    job_ready = 1'b1; ecdsa_ready = 1'b0;
    applyStimulus(1'b1, mkHash(), 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 49; i++) begin
      applyStimulus(1'b0, '0, 1'b1, mkHdr(32'h77), 16'd3, i == 0, i == 48);
      if (i == 47) begin
        checks++;
        if (ecdsa_lh_ready !== 1'b1) begin failures++; $display("[TB] FAIL thr_48 got %b expected 1", ecdsa_lh_ready); end
      end
    end
    checks++;
    if (ecdsa_lh_ready !== 1'b0) begin failures++; $display("[TB] FAIL thr_49 got %b expected 0", ecdsa_lh_ready); end
    ecdsa_ready = 1'b1;
    idle();
    ecdsa_ready = 1'b0;
    checks++;
    if (ecdsa_lh_ready !== 1'b1 || obsBeats.size() != 1) begin
      failures++;
      $display("[TB] FAIL thr_pop got ready=%b beats=%0d expected ready=1 beats=1", ecdsa_lh_ready, obsBeats.size());
    end
    ecdsa_ready = 1'b1;
    drain(300);
    checkOutput("thr");
    clearQueues();
  endtask

  task automatic test_random();
    int c;
    bit hashFirst;
    logic [HW-1:0] h;
    randReady = 1'b1;
    for (int p = 0; p < 20; p++) begin
      c = 0;
      while ((!ecdsa_lh_ready || int'(expJobs.size()) - int'(obsJobs.size()) > 3) && c < 500) begin
        idle();
        c++;
      end
      if (c >= 500) begin
        checks++; failures++;
        $display("[TB] FAIL rand_wait timeout packet=%0d", p);
      end
      h = mkHash();
      hashFirst = ($urandom_range(0, 1) == 1);
      if (hashFirst) applyStimulus(1'b1, h, 1'b0, '0, '0, 1'b0, 1'b0);
      sendPacket(16'($urandom), $urandom, $urandom_range(1, 6));
      if (!hashFirst) applyStimulus(1'b1, h, 1'b0, '0, '0, 1'b0, 1'b0);
    end
    randReady = 1'b0;
    job_ready = 1'b1; ecdsa_ready = 1'b1;
    drain(1000);
    checkOutput("rand");
    clearQueues();
  endtask

  task automatic test_overflow();
    job_ready = 1'b1; ecdsa_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, mkHash(), 1'b0, '0, '0, 1'b0, 1'b0);
      if (i == 5 || i == 6) begin
        checks++;
        if (ecdsa_lh_ready !== (i == 5)) begin
          failures++;
          $display("[TB] FAIL ovf_ready_after_%0d got %b expected %b", i + 1, ecdsa_lh_ready, i == 5);
        end
      end
    end
    checks++;
    if (err_overflow !== expErr || expErr !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_err got %b expected %b", err_overflow, expErr);
    end
    for (int p = 0; p < 8; p++) sendPacket(16'(p), $urandom, $urandom_range(1, 3));
    drain(500);
    checkOutput("ovf");
    clearQueues();
  endtask

  task automatic test_reset_mid_data();
    job_ready = 1'b1; ecdsa_ready = 1'b0;
    applyStimulus(1'b1, mkHash(), 1'b0, '0, '0, 1'b0, 1'b0);
    sendPacket(16'd7, 32'h44, 6);
    ecdsa_ready = 1'b1;
    idle();
    idle();
    ecdsa_ready = 1'b0;
    checks++;
    if (ecdsa_valid !== 1'b1 || obsBeats.size() != 2) begin
      failures++;
      $display("[TB] FAIL mid_pre got valid=%b beats=%0d expected valid=1 beats=2", ecdsa_valid, obsBeats.size());
    end
    reset = 1'b1;
    ecdsa_ready = 1'b1;
    @(posedge clk); #1;
    checks += 5;
    if (job_valid !== 1'b0)      begin failures++; $display("[TB] FAIL mid_job_valid got %b expected 0", job_valid); end
    if (ecdsa_valid !== 1'b0)    begin failures++; $display("[TB] FAIL mid_ecdsa_valid got %b expected 0", ecdsa_valid); end
    if (err_overflow !== 1'b0)   begin failures++; $display("[TB] FAIL mid_err got %b expected 0", err_overflow); end
    if (job_cnt !== 16'd0)       begin failures++; $display("[TB] FAIL mid_job_cnt got %0d expected 0", job_cnt); end
    if (ecdsa_lh_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_ready got %b expected 0", ecdsa_lh_ready); end
    reset = 1'b0;
    expJobs.delete(); obsJobs.delete(); expBeats.delete(); obsBeats.delete();
    mHash.delete(); mMeta.delete();
    totalJobs = 0;
    expErr = 1'b0;
    repeat (5) idle();
    applyStimulus(1'b1, mkHash(), 1'b0, '0, '0, 1'b0, 1'b0);
    sendPacket(16'd2, 32'h99, 2);
    drain(200);
    checkOutput("mid");
    clearQueues();
  endtask

  initial begin
    reset = 1'b1;
    lh_ecdsa_hash_valid = 1'b0; lh_ecdsa_hash_data = '0;
    lh_ecdsa_valid = 1'b0; lh_ecdsa_hdr_data = '0; lh_ecdsa_meta_data = '0;
    lh_ecdsa_sop = 1'b0; lh_ecdsa_eop = 1'b0;
    job_ready = 1'b1; ecdsa_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_hash_late();
    test_ready_threshold();
    test_random();
    test_overflow();
    test_reset_mid_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
